alu_seq_core: RTL



---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_mul.sv | 61 ++++++
 rtl/alu_seq_core.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU core and its multiplier.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle,
// WIDTH steps per product. done is high during the last step, with product valid.
module alu_seq_mul
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   logic             busy;
   logic [CW-1:0]    step_cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] prod_hi;
   logic [WIDTH-1:0] prod_lo;
   logic [WIDTH:0]   step_sum;
   logic [WIDTH-1:0] hi_nxt;
   logic [WIDTH-1:0] lo_nxt;

   // prod_lo starts as the multiplier and is shifted out as product bits shift in
   always_comb begin
      step_sum = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
      hi_nxt   = step_sum[WIDTH:1];
      lo_nxt   = {step_sum[0], prod_lo[WIDTH-1:1]};
      done     = busy && (step_cnt == LAST_STEP);
      product  = {hi_nxt, lo_nxt};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         step_cnt <= '0;
         mcand    <= '0;
         prod_hi  <= '0;
         prod_lo  <= '0;
      end else if (start) begin
         busy     <= 1'b1;
         step_cnt <= '0;
         mcand    <= a;
         prod_hi  <= '0;
         prod_lo  <= b;
      end else if (busy) begin
         prod_hi  <= hi_nxt;
         prod_lo  <= lo_nxt;
         step_cnt <= step_cnt + 1'b1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with accumulator, valid/ready handshakes and iterative multiply.
//   state   | meaning
//   IDLE    | ready for an operation; single-cycle ops computed and registered on accept
//   MUL     | multiplier stepping; inputs ignored
//   DONE    | result held on out_* until out_ready
module alu_seq_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic             in_acc,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_lo,
   output logic [WIDTH-1:0] out_hi,
   output logic [3:0]       out_flags
);

   localparam int SW = $clog2(WIDTH);

   state_e             state;
   state_e             state_nxt;
   op_e                op;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   op_a;
   logic [SW-1:0]      sh_amt;
   logic [WIDTH:0]     add_w;
   logic [WIDTH:0]     sub_w;
   logic [WIDTH:0]     shl_w;
   logic [WIDTH:0]     shr_w;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic               load_alu;
   logic               load_mul;
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   assign op = op_e'(in_op);

   // Shifts carry one spare bit so the last bit shifted out lands in it
   always_comb begin
      op_a    = in_acc ? acc : in_a;
      sh_amt  = in_b[SW-1:0];
      add_w   = {1'b0, op_a} + {1'b0, in_b};
      sub_w   = {1'b0, op_a} - {1'b0, in_b};
      shl_w   = {1'b0, op_a} << sh_amt;
      shr_w   = {op_a, 1'b0} >> sh_amt;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = add_w[WIDTH-1:0];
            alu_c   = add_w[WIDTH];
            alu_v   = (op_a[WIDTH-1] == in_b[WIDTH-1]) && (add_w[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sub_w[WIDTH-1:0];
            alu_c   = sub_w[WIDTH];
            alu_v   = (op_a[WIDTH-1] != in_b[WIDTH-1]) && (sub_w[WIDTH-1] != op_a[WIDTH-1]);
         end
         OP_AND: alu_res = op_a & in_b;
         OP_OR:  alu_res = op_a | in_b;
         OP_XOR: alu_res = op_a ^ in_b;
         OP_SHL: begin
            alu_res = shl_w[WIDTH-1:0];
            alu_c   = shl_w[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_w[WIDTH:1];
            alu_c   = shr_w[0];
         end
         default: ;
      endcase
   end

   alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (op_a),
      .b       (in_b),
      .done    (mul_done),
      .product (mul_prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (in_valid)  state_nxt = (op == OP_MUL) ? ST_MUL : ST_DONE;
         ST_MUL:  if (mul_done)  state_nxt = ST_DONE;
         ST_DONE: if (out_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // in_ready is gated by rst_n so nothing is offered while reset is held
   always_comb begin
      in_ready  = (state == ST_IDLE) && rst_n;
      out_valid = (state == ST_DONE);
      load_alu  = (state == ST_IDLE) && in_valid && (op != OP_MUL);
      mul_start = (state == ST_IDLE) && in_valid && (op == OP_MUL);
      load_mul  = (state == ST_MUL) && mul_done;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         out_lo    <= '0;
         out_hi    <= '0;
         out_flags <= '0;
      end else if (load_alu) begin
         acc               <= alu_res;
         out_lo            <= alu_res;
         out_hi            <= '0;
         out_flags[FLAG_N] <= alu_res[WIDTH-1];
         out_flags[FLAG_Z] <= (alu_res == '0);
         out_flags[FLAG_C] <= alu_c;
         out_flags[FLAG_V] <= alu_v;
      end else if (load_mul) begin
         acc               <= mul_prod[WIDTH-1:0];
         out_lo            <= mul_prod[WIDTH-1:0];
         out_hi            <= mul_prod[2*WIDTH-1:WIDTH];
         out_flags[FLAG_N] <= mul_prod[2*WIDTH-1];
         out_flags[FLAG_Z] <= (mul_prod == '0);
         out_flags[FLAG_C] <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
         out_flags[FLAG_V] <= 1'b0;
      end
   end

endmodule
